// File: rtl/wb_regfile_pkg.sv
// Core-wide register-file definitions.
// The decode stage and the hazard unit reuse these definitions.
package wb_regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = 16;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // R0 is the hardwired-zero register.
    localparam reg_idx_t REG_ZERO = '0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_regfile_core.sv
// Storage for the 8 x 16-bit architectural registers.
// This block applies the R0 rule, performs the commit and clears on reset.
// It exposes raw read data with no bypass.
module regfile_core
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    word_t regs_q [NUM_REGS];

    // Commit one register per edge. Writes to R0 are dropped here.
    // NOTE: this array is small and must read zero after reset, so every entry is reset here; large RAMs normally are not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: sequential state uses non-blocking assignments so that all flops update together at the edge.
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == REG_ZERO) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == REG_ZERO) ? '0 : regs_q[raddr2_i];

endmodule : regfile_core

// File: rtl/wb_regfile.sv
// Write-back side of the MEM/WB pipeline register.
// This block selects the write-back data and commits it to the register file.
// It also serves the two bypassed decode read ports and counts committed write-backs.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_RegWrite,
    input  logic              in_MemtoReg,
    input  logic [DATA_W-1:0] in_ReadData,
    input  logic [DATA_W-1:0] in_ALUResult,
    input  logic [ADDR_W-1:0] in_WriteReg,
    input  logic [ADDR_W-1:0] in_ReadReg1,
    input  logic [ADDR_W-1:0] in_ReadReg2,
    output logic [DATA_W-1:0] O_ReadData1,
    output logic [DATA_W-1:0] O_ReadData2,
    output logic [DATA_W-1:0] O_WriteData,
    output logic [CNT_W-1:0]  O_WbCount
);

    word_t write_data;
    word_t raw_rdata1;
    word_t raw_rdata2;
    logic  commit;
    logic  bypass1;
    logic  bypass2;
    cnt_t  wb_cnt_q;
    cnt_t  wb_cnt_d;

    assign write_data = in_MemtoReg ? in_ReadData : in_ALUResult;

    // A commit happens only when reset is released.
    // Because R0 is excluded, R0 writes are never bypassed.
    assign commit  = rst_n && in_RegWrite && (in_WriteReg != REG_ZERO);
    assign bypass1 = commit && (in_ReadReg1 == in_WriteReg);
    assign bypass2 = commit && (in_ReadReg2 == in_WriteReg);

    regfile_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (in_RegWrite),
        .waddr_i  (in_WriteReg),
        .wdata_i  (write_data),
        .raddr1_i (in_ReadReg1),
        .raddr2_i (in_ReadReg2),
        .rdata1_o (raw_rdata1),
        .rdata2_o (raw_rdata2)
    );

    assign O_WriteData = write_data;
    assign O_ReadData1 = bypass1 ? write_data : raw_rdata1;
    assign O_ReadData2 = bypass2 ? write_data : raw_rdata2;

    // Next count: step on each commit and stop at all-ones.
    always_comb begin
        // NOTE: the default comes first, so every path assigns wb_cnt_d and no latch is inferred.
        wb_cnt_d = wb_cnt_q;
        if (commit && (wb_cnt_q != '1)) begin
            wb_cnt_d = wb_cnt_q + cnt_t'(1);
        end
    end

    // Write-back counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cnt_q <= '0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
        end
    end

    assign O_WbCount = wb_cnt_q;

endmodule : wb_regfile
